zap_shifter_arbiter: RTL and testbench



---
 rtl/zap_shifter_arbiter.sv | 167 ++++++++++++++++
 tb/tb_zap_shifter_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_shifter_arbiter.sv
// Round-robin arbiter sharing one external barrel shifter between two requesters.
// Optional per-requester sticky saturation flags: define ZAP_SHIFTER_ARB_STICKY_SAT_EN.
//
//   state | meaning
//   IDLE  | waiting for a request; grants one requester and latches its operands
//   EXEC  | issue registers drive the shifter; result captured at end of cycle
//   RESP  | response held for the owner until it asserts rsp_ready
module zap_shifter_arbiter #(
    parameter  int SHIFT_OPS = 5,
    localparam int TW        = $clog2(SHIFT_OPS)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_flush,
    input  logic          i_r0_valid,
    input  logic          i_r1_valid,
    output logic          o_r0_ready,
    output logic          o_r1_ready,
    input  logic [31:0]   i_r0_source,
    input  logic [31:0]   i_r1_source,
    input  logic [7:0]    i_r0_amount,
    input  logic [7:0]    i_r1_amount,
    input  logic          i_r0_carry,
    input  logic          i_r1_carry,
    input  logic [TW-1:0] i_r0_type,
    input  logic [TW-1:0] i_r1_type,
    output logic [31:0]   o_sh_source,
    output logic [7:0]    o_sh_amount,
    output logic          o_sh_carry,
    output logic [TW-1:0] o_sh_type,
    input  logic [31:0]   i_sh_result,
    input  logic          i_sh_carry,
    input  logic          i_sh_sat,
    output logic          o_r0_rsp_valid,
    output logic          o_r1_rsp_valid,
    input  logic          i_r0_rsp_ready,
    input  logic          i_r1_rsp_ready,
`ifdef ZAP_SHIFTER_ARB_STICKY_SAT_EN
    input  logic          i_r0_sat_clr,
    input  logic          i_r1_sat_clr,
    output logic          o_r0_sticky_sat,
    output logic          o_r1_sticky_sat,
`endif
    output logic [31:0]   o_rsp_result,
    output logic          o_rsp_carry,
    output logic          o_rsp_sat
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          owner_q, owner_d;
    logic [31:0]   src_q, src_d;
    logic [7:0]    amt_q, amt_d;
    logic          cin_q, cin_d;
    logic [TW-1:0] type_q, type_d;
    logic [31:0]   res_q, res_d;
    logic          rcarry_q, rcarry_d;
    logic          sat_q, sat_d;
    logic          grant0, grant1, rsp_hs;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        src_d      = src_q;
        amt_d      = amt_q;
        cin_d      = cin_q;
        type_d     = type_q;
        res_d      = res_q;
        rcarry_d   = rcarry_q;
        sat_d      = sat_q;
        o_r0_ready = 1'b0;
        o_r1_ready = 1'b0;
        rsp_hs     = 1'b0;
        // ptr_q holds the last granted requester; r0 wins a tie when r1 went last
        grant0     = i_r0_valid && (!i_r1_valid || ptr_q);
        grant1     = i_r1_valid && !grant0;

        case (state_q)
            IDLE: begin
                if (i_reset_n && !i_flush && (grant0 || grant1)) begin
                    o_r0_ready = grant0;
                    o_r1_ready = grant1;
                    owner_d    = grant1;
                    ptr_d      = grant1;
                    src_d      = grant1 ? i_r1_source : i_r0_source;
                    amt_d      = grant1 ? i_r1_amount : i_r0_amount;
                    cin_d      = grant1 ? i_r1_carry  : i_r0_carry;
                    type_d     = grant1 ? i_r1_type   : i_r0_type;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                res_d    = i_sh_result;
                rcarry_d = i_sh_carry;
                sat_d    = i_sh_sat;
                state_d  = RESP;
            end
            RESP: begin
                rsp_hs = owner_q ? i_r1_rsp_ready : i_r0_rsp_ready;
                if (rsp_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (i_flush) state_d = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b1;
            owner_q  <= 1'b0;
            src_q    <= '0;
            amt_q    <= '0;
            cin_q    <= 1'b0;
            type_q   <= '0;
            res_q    <= '0;
            rcarry_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            src_q    <= src_d;
            amt_q    <= amt_d;
            cin_q    <= cin_d;
            type_q   <= type_d;
            res_q    <= res_d;
            rcarry_q <= rcarry_d;
            sat_q    <= sat_d;
        end
    end

    assign o_sh_source    = src_q;
    assign o_sh_amount    = amt_q;
    assign o_sh_carry     = cin_q;
    assign o_sh_type      = type_q;
    assign o_rsp_result   = res_q;
    assign o_rsp_carry    = rcarry_q;
    assign o_rsp_sat      = sat_q;
    assign o_r0_rsp_valid = (state_q == RESP) && !owner_q;
    assign o_r1_rsp_valid = (state_q == RESP) &&  owner_q;

`ifdef ZAP_SHIFTER_ARB_STICKY_SAT_EN
    logic [1:0] sticky_q, sticky_d;

    // clear is applied last so it wins over a same-cycle set
    always_comb begin
        sticky_d = sticky_q;
        if (rsp_hs && sat_q) sticky_d[owner_q] = 1'b1;
        if (i_r0_sat_clr)    sticky_d[0]       = 1'b0;
        if (i_r1_sat_clr)    sticky_d[1]       = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) sticky_q <= '0;
        else            sticky_q <= sticky_d;
    end

    assign o_r0_sticky_sat = sticky_q[0];
    assign o_r1_sticky_sat = sticky_q[1];
`endif

endmodule

// File: tb/tb_zap_shifter_arbiter.sv
// Bench for zap_shifter_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model; includes a behavioural model of the shared shifter.
module tb_zap_shifter_arbiter;
    localparam int TW = $clog2(5);

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_flush = 1'b0;
    logic [1:0]    v, rr, clr;
    logic [31:0]   src [2];
    logic [7:0]    amt [2];
    logic          cin [2];
    logic [TW-1:0] typ [2];
    logic          rdy0, rdy1, rv0, rv1;
    logic [31:0]   o_sh_source, o_rsp_result, sh_result;
    logic [7:0]    o_sh_amount;
    logic          o_sh_carry, o_rsp_carry, o_rsp_sat, sh_carry, sh_sat;
    logic [TW-1:0] o_sh_type;
`ifdef ZAP_SHIFTER_ARB_STICKY_SAT_EN
    logic          sticky0, sticky1;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    zap_shifter_arbiter #(.SHIFT_OPS(5)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
        .i_r0_valid(v[0]), .i_r1_valid(v[1]),
        .o_r0_ready(rdy0), .o_r1_ready(rdy1),
        .i_r0_source(src[0]), .i_r1_source(src[1]),
        .i_r0_amount(amt[0]), .i_r1_amount(amt[1]),
        .i_r0_carry(cin[0]), .i_r1_carry(cin[1]),
        .i_r0_type(typ[0]), .i_r1_type(typ[1]),
        .o_sh_source(o_sh_source), .o_sh_amount(o_sh_amount),
        .o_sh_carry(o_sh_carry), .o_sh_type(o_sh_type),
        .i_sh_result(sh_result), .i_sh_carry(sh_carry), .i_sh_sat(sh_sat),
        .o_r0_rsp_valid(rv0), .o_r1_rsp_valid(rv1),
        .i_r0_rsp_ready(rr[0]), .i_r1_rsp_ready(rr[1]),
`ifdef ZAP_SHIFTER_ARB_STICKY_SAT_EN
        .i_r0_sat_clr(clr[0]), .i_r1_sat_clr(clr[1]),
        .o_r0_sticky_sat(sticky0), .o_r1_sticky_sat(sticky1),
`endif
        .o_rsp_result(o_rsp_result), .o_rsp_carry(o_rsp_carry), .o_rsp_sat(o_rsp_sat)
    );

    // Types: 0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 LSL_SAT. Returns {sat, carry, result}.
    function automatic logic [33:0] ref_shift(input logic [TW-1:0] t, input logic [31:0] s,
                                              input logic [7:0] a, input logic c);
        logic [63:0]        w;
        logic signed [63:0] ws;
        logic [31:0]        r;
        logic               co, sat;
        int                 n, m;
        n = int'(a); r = s; co = c; sat = 1'b0;
        case (t)
            0: begin w = {32'b0, s} << n; r = w[31:0]; if (n != 0) co = w[32]; end
            1: begin w = {s, 32'b0} >> n; r = w[63:32]; if (n != 0) co = w[31]; end
            2: begin ws = $signed({s, 32'b0}) >>> n; r = ws[63:32]; if (n != 0) co = ws[31]; end
            3: begin
                m = n % 32;
                r = (m == 0) ? s : ((s >> m) | (s << (32 - m)));
                if (n != 0) co = r[31];
            end
            4: begin
                ws = $signed({{32{s[31]}}, s}) <<< ((n > 32) ? 32 : n);
                if (ws > 64'sd2147483647) begin r = 32'h7FFF_FFFF; sat = 1'b1; end
                else if (ws < -64'sd2147483648) begin r = 32'h8000_0000; sat = 1'b1; end
                else r = ws[31:0];
            end
            default: ;
        endcase
        return {sat, co, r};
    endfunction

    always_comb {sh_sat, sh_carry, sh_result} = ref_shift(o_sh_type, o_sh_source, o_sh_amount, o_sh_carry);

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one outstanding op, response two cycles after accept.
    logic          m_busy = 1'b0;
    int            m_age = 0;
    int            m_own = 0;
    int            m_last = 1;
    logic [TW-1:0] m_typ;
    logic [31:0]   m_src;
    logic [7:0]    m_amt;
    logic          m_cin;
    logic [1:0]    m_sticky = 2'b00;
    int            acc_cnt [2] = '{0, 0};

    always @(negedge i_clk) begin
        int          win;
        logic        erv, hs;
        logic [33:0] e;
        win = -1;
        e   = '0;
        if (i_reset_n && !i_flush && !m_busy && (v[0] || v[1]))
            win = (v[0] && v[1]) ? (1 - m_last) : (v[0] ? 0 : 1);
        erv = m_busy && (m_age >= 2);
        check_val("r0_ready", 32'(rdy0), 32'(win == 0));
        check_val("r1_ready", 32'(rdy1), 32'(win == 1));
        check_val("r0_rsp_valid", 32'(rv0), 32'(erv && m_own == 0));
        check_val("r1_rsp_valid", 32'(rv1), 32'(erv && m_own == 1));
        if (erv) begin
            e = ref_shift(m_typ, m_src, m_amt, m_cin);
            check_val("rsp_result", o_rsp_result, e[31:0]);
            check_val("rsp_carry", 32'(o_rsp_carry), 32'(e[32]));
            check_val("rsp_sat", 32'(o_rsp_sat), 32'(e[33]));
        end
`ifdef ZAP_SHIFTER_ARB_STICKY_SAT_EN
        check_val("r0_sticky", 32'(sticky0), 32'(m_sticky[0]));
        check_val("r1_sticky", 32'(sticky1), 32'(m_sticky[1]));
`endif
        if (!i_reset_n) begin
            m_busy = 1'b0; m_last = 1; m_sticky = 2'b00;
        end else begin
            hs = erv && rr[m_own];
            if (hs && e[33]) m_sticky[m_own] = 1'b1;
            if (clr[0]) m_sticky[0] = 1'b0;
            if (clr[1]) m_sticky[1] = 1'b0;
            if (i_flush || hs) m_busy = 1'b0;
            else if (win >= 0) begin
                m_busy = 1'b1; m_age = 1; m_own = win; m_last = win;
                m_typ = typ[win]; m_src = src[win]; m_amt = amt[win]; m_cin = cin[win];
                acc_cnt[win]++;
            end else if (m_busy) m_age++;
        end
    end

    task automatic tick();
        @(posedge i_clk); #1;
    endtask

    task automatic set_req(input int r, input logic [TW-1:0] t, input logic [31:0] s,
                           input logic [7:0] a, input logic c);
        v[r] = 1'b1; typ[r] = t; src[r] = s; amt[r] = a; cin[r] = c;
    endtask

    task automatic wait_acc(input int r);
        int start;
        bit got;
        start = acc_cnt[r];
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (acc_cnt[r] != start) got = 1'b1;
        end
        if (!got) check_val("accept_timeout", 32'd0, 32'd1);
        v[r] = 1'b0;
    endtask

    initial begin
        int n0, n1;
        int prev [2];
        v = '0; rr = 2'b11; clr = '0;
        for (int r = 0; r < 2; r++) begin src[r] = '0; amt[r] = '0; cin[r] = 1'b0; typ[r] = '0; end

        // Reset values
        repeat (3) tick();
        @(negedge i_clk);
        check_val("rst_rsp_result", o_rsp_result, 32'd0);
        check_val("rst_rsp_carry", 32'(o_rsp_carry), 32'd0);
        check_val("rst_rsp_sat", 32'(o_rsp_sat), 32'd0);
        check_val("rst_sh_source", o_sh_source, 32'd0);
        check_val("rst_sh_amount", 32'(o_sh_amount), 32'd0);
        check_val("rst_sh_type", 32'(o_sh_type), 32'd0);
        tick();
        i_reset_n = 1'b1;

        // Single LSL, latency N -> N+2
        set_req(0, 0, 32'h0000_0001, 8'd4, 1'b0);
        wait_acc(0);
        @(negedge i_clk);
        check_val("lat_n1_no_valid", 32'(rv0), 32'd0);
        @(negedge i_clk);
        check_val("lat_n2_valid", 32'(rv0), 32'd1);
        check_val("lsl_result", o_rsp_result, 32'h0000_0010);
        check_val("lsl_carry", 32'(o_rsp_carry), 32'd0);
        repeat (2) tick();

        // Tie after reset: r0 first, then r1
        i_reset_n = 1'b0; tick(); i_reset_n = 1'b1;
        set_req(0, 0, 32'h0000_0003, 8'd1, 1'b0);
        set_req(1, 1, 32'h8000_0000, 8'd1, 1'b0);
        n1 = acc_cnt[1];
        wait_acc(0);
        check_val("tie_r0_first", 32'(acc_cnt[1] - n1), 32'd0);
        wait_acc(1);
        @(negedge i_clk); @(negedge i_clk);
        check_val("r1_lsr_valid", 32'(rv1), 32'd1);
        check_val("r1_lsr_result", o_rsp_result, 32'h4000_0000);
        check_val("r1_lsr_carry", 32'(o_rsp_carry), 32'd0);
        repeat (2) tick();

        // Owner stalls in RESP for 5 cycles while r1 waits
        rr[0] = 1'b0;
        set_req(0, 3, 32'h0000_00F1, 8'd4, 1'b0);
        wait_acc(0);
        @(negedge i_clk); @(negedge i_clk);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) set_req(1, 2, 32'h8000_0000, 8'd3, 1'b0);
            @(negedge i_clk);
            check_val("hold_valid", 32'(rv0), 32'd1);
            check_val("hold_result", o_rsp_result, 32'h1000_000F);
            check_val("hold_r1_ready", 32'(rdy1), 32'd0);
        end
        tick();
        rr[0] = 1'b1;
        wait_acc(1);
        repeat (4) tick();

        // LSL_SAT via r1 and sticky flag
        set_req(1, 4, 32'h4000_0000, 8'd1, 1'b0);
        wait_acc(1);
        @(negedge i_clk); @(negedge i_clk);
        check_val("sat_valid", 32'(rv1), 32'd1);
        check_val("sat_result", o_rsp_result, 32'h7FFF_FFFF);
        check_val("sat_flag", 32'(o_rsp_sat), 32'd1);
        tick();
`ifdef ZAP_SHIFTER_ARB_STICKY_SAT_EN
        @(negedge i_clk);
        check_val("sticky_set", 32'(sticky1), 32'd1);
        repeat (2) tick();
        @(negedge i_clk);
        check_val("sticky_held", 32'(sticky1), 32'd1);
        tick(); clr[1] = 1'b1; tick(); clr[1] = 1'b0;
        @(negedge i_clk);
        check_val("sticky_clr", 32'(sticky1), 32'd0);
`endif
        repeat (2) tick();

        // Flush in EXEC: no response, pointer unchanged (r0 was last, so r1 wins tie)
        set_req(0, 0, 32'h0000_0005, 8'd1, 1'b0);
        wait_acc(0);
        i_flush = 1'b1; tick(); i_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check_val("flush_no_rsp", 32'(rv0), 32'd0);
        end
        tick();
        set_req(0, 1, 32'h0000_0100, 8'd2, 1'b0);
        set_req(1, 0, 32'h0000_0100, 8'd2, 1'b0);
        n0 = acc_cnt[0];
        wait_acc(1);
        check_val("flush_ptr_kept", 32'(acc_cnt[0] - n0), 32'd0);
        wait_acc(0);
        repeat (4) tick();

        // Reset during RESP
        rr[0] = 1'b0;
        set_req(0, 0, 32'h0000_0007, 8'd2, 1'b1);
        wait_acc(0);
        @(negedge i_clk); @(negedge i_clk);
        tick();
        i_reset_n = 1'b0;
        tick();
        @(negedge i_clk);
        check_val("rstresp_rv0", 32'(rv0), 32'd0);
        check_val("rstresp_rdy0", 32'(rdy0), 32'd0);
        check_val("rstresp_result", o_rsp_result, 32'd0);
        check_val("rstresp_sh_source", o_sh_source, 32'd0);
        tick();
        i_reset_n = 1'b1; rr = 2'b11;

        // Randomized traffic
        prev[0] = acc_cnt[0]; prev[1] = acc_cnt[1];
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            for (int r = 0; r < 2; r++) begin
                if (acc_cnt[r] != prev[r]) begin v[r] = 1'b0; prev[r] = acc_cnt[r]; end
                if (!v[r] && $urandom_range(0, 2) == 0)
                    set_req(r, TW'($urandom_range(0, 4)), $urandom, 8'($urandom_range(0, 40)),
                            1'($urandom_range(0, 1)));
                rr[r]  = ($urandom_range(0, 3) != 0);
                clr[r] = ($urandom_range(0, 15) == 0);
            end
            i_flush   = ($urandom_range(0, 39) == 0);
            i_reset_n = ($urandom_range(0, 499) != 0);
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
